// File: rtl/uart_beacon_tx.sv
// uart_beacon_tx: serial message beacon.
// A small character buffer is loaded while idle, then sent as a run of
// back-to-back UART frames. The run can optionally repeat after an
// idle-line gap. A stop request ends the run at the next frame boundary.
// txd is decoded from the registered FSM state, so it changes only on clock edges.
module uart_beacon_tx #(
  parameter int CLK_HZ              = 500000,
  parameter int BIT_RATE            = 9600,
  parameter int PAYLOAD_BITS        = 8,
  parameter int PARITY              = 0,
  parameter int STOP_BITS           = 1,
  parameter int MSG_DEPTH           = 16,
  parameter int REPEAT_DELAY_CYCLES = 500000,
  parameter int AW                  = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1,
  parameter int LW                  = $clog2(MSG_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    repeat_en,
  input  logic [LW-1:0]           msg_len,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  output logic                    txd,
  output logic                    busy,
  output logic                    char_done,
  output logic                    msg_done,
  output logic                    wr_err
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  // A zero repeat delay still spends one idle-line cycle in DELAY.
  localparam int RD  = (REPEAT_DELAY_CYCLES < 1) ? 1 : REPEAT_DELAY_CYCLES;
  localparam int DW  = $clog2(RD + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(RD - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(MSG_DEPTH);
  localparam logic [2:0]    DATA_LAST = 3'(PAYLOAD_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_DELAY} state_t;
  typedef enum logic [1:0] {PH_START, PH_DATA, PH_PARITY, PH_STOP} phase_t;

  state_t                  state, state_n;
  phase_t                  phase, phase_n;
  logic [CW-1:0]           bit_cnt, bit_cnt_n;
  logic [2:0]              bit_idx, bit_idx_n;
  logic [LW-1:0]           char_idx, char_idx_n;
  logic [LW-1:0]           len_q, len_n;
  logic                    rep_q, rep_n;
  logic                    stop_q, stop_n;
  logic [DW-1:0]           dly_cnt, dly_cnt_n;

  logic [PAYLOAD_BITS-1:0] mem [MSG_DEPTH];
  logic [PAYLOAD_BITS-1:0] cur_char;
  logic                    par_bit;
  logic                    bit_end;
  logic                    last_char;

  assign cur_char  = mem[char_idx[AW-1:0]];
  assign par_bit   = (PARITY == 2) ? ~(^cur_char) : ^cur_char;
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign last_char = ((char_idx + 1'b1) == len_q);
  assign busy      = (state != ST_IDLE);

  // Message buffer: written only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == ST_IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-while-busy error, registered so it is a clean one-cycle pulse per attempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && (state != ST_IDLE);
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= PH_START;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      len_q    <= '0;
      rep_q    <= 1'b0;
      stop_q   <= 1'b0;
      dly_cnt  <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      char_idx <= char_idx_n;
      len_q    <= len_n;
      rep_q    <= rep_n;
      stop_q   <= stop_n;
      dly_cnt  <= dly_cnt_n;
    end
  end

  // Next-state, line level and done pulses.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    char_idx_n = char_idx;
    len_n      = len_q;
    rep_n      = rep_q;
    stop_n     = stop_q;
    dly_cnt_n  = dly_cnt;
    txd        = 1'b1;
    char_done  = 1'b0;
    msg_done   = 1'b0;

    case (state)
      ST_IDLE: begin
        stop_n = 1'b0;
        if (start && msg_len != '0) begin
          state_n    = ST_FRAME;
          phase_n    = PH_START;
          bit_cnt_n  = '0;
          bit_idx_n  = '0;
          char_idx_n = '0;
          len_n      = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
          rep_n      = repeat_en;
        end
      end

      ST_FRAME: begin
        // A stop request is remembered until the current frame completes.
        stop_n    = stop_q | stop;
        bit_cnt_n = bit_cnt + 1'b1;
        case (phase)
          PH_START: begin
            txd = 1'b0;
            if (bit_end) begin
              bit_cnt_n = '0;
              bit_idx_n = '0;
              phase_n   = PH_DATA;
            end
          end
          PH_DATA: begin
            txd = cur_char[bit_idx];
            if (bit_end) begin
              bit_cnt_n = '0;
              if (bit_idx == DATA_LAST) begin
                bit_idx_n = '0;
                phase_n   = (PARITY != 0) ? PH_PARITY : PH_STOP;
              end else begin
                bit_idx_n = bit_idx + 1'b1;
              end
            end
          end
          PH_PARITY: begin
            txd = par_bit;
            if (bit_end) begin
              bit_cnt_n = '0;
              bit_idx_n = '0;
              phase_n   = PH_STOP;
            end
          end
          default: begin
            txd = 1'b1;
            if (bit_end) begin
              bit_cnt_n = '0;
              if (bit_idx == STOP_LAST) begin
                char_done = 1'b1;
                bit_idx_n = '0;
                phase_n   = PH_START;
                // Stop outranks both the next character and a repeat.
                if (stop_n) begin
                  state_n = ST_IDLE;
                end else if (last_char) begin
                  msg_done   = 1'b1;
                  char_idx_n = '0;
                  if (rep_q) begin
                    state_n   = ST_DELAY;
                    dly_cnt_n = '0;
                  end else begin
                    state_n = ST_IDLE;
                  end
                end else begin
                  char_idx_n = char_idx + 1'b1;
                end
              end else begin
                bit_idx_n = bit_idx + 1'b1;
              end
            end
          end
        endcase
      end

      ST_DELAY: begin
        dly_cnt_n = dly_cnt + 1'b1;
        if (stop) begin
          state_n = ST_IDLE;
        end else if (dly_cnt == DLY_LAST) begin
          state_n    = ST_FRAME;
          phase_n    = PH_START;
          bit_cnt_n  = '0;
          bit_idx_n  = '0;
          char_idx_n = '0;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // A reset abandons the frame, so no completion may be reported in that cycle.
    if (rst) begin
      char_done = 1'b0;
      msg_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_beacon_tx.sv
// Directed bench for uart_beacon_tx. Instance a uses 8N1 framing with a
// 1000-cycle repeat gap. Instance b uses 8O2 framing. Both run at CPB = 52.
// Cycle 1 is the first start-bit cycle after start is sampled.
module tb_uart_beacon_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_start, b_start, stop, repeat_en;
  logic [4:0] msg_len;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       a_txd, a_busy, a_char_done, a_msg_done, a_wr_err;
  logic       b_txd, b_busy, b_char_done, b_msg_done, b_wr_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_byte;

  // Clock generation.
  always #5 clk = ~clk;

  uart_beacon_tx #(.REPEAT_DELAY_CYCLES(1000)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(stop), .repeat_en(repeat_en),
    .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .txd(a_txd), .busy(a_busy), .char_done(a_char_done), .msg_done(a_msg_done),
    .wr_err(a_wr_err)
  );

  uart_beacon_tx #(.PARITY(2), .STOP_BITS(2), .REPEAT_DELAY_CYCLES(1000)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(stop), .repeat_en(repeat_en),
    .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .txd(b_txd), .busy(b_busy), .char_done(b_char_done), .msg_done(b_msg_done),
    .wr_err(b_wr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulse start on one instance; returns at cycle 1.
  task automatic go(input bit use_b);
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    cyc = 1;
  endtask

  task automatic pulse_stop(input int c);
    to_cycle(c);
    stop = 1'b1;
    to_cycle(c + 1);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    msg_len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_txd", a_txd, 1);
    check("rst_busy", a_busy, 0);
    check("rst_char_done", a_char_done, 0);
    check("rst_msg_done", a_msg_done, 0);
    check("rst_wr_err", a_wr_err, 0);
    check("rst_b_txd", b_txd, 1);
    check("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    wr(4'd0, 8'h48);
    wr(4'd1, 8'h69);
    wr(4'd2, 8'h0A);

    // Single 'H' frame, with a start pulse mid-frame that must be ignored.
    msg_len = 5'd1; repeat_en = 1'b0;
    go(1'b0);
    check("t1_busy_c1", a_busy, 1);
    check("t1_txd_c1", a_txd, 0);
    to_cycle(52);  check("t1_txd_c52", a_txd, 0);
    exp_byte = 8'h48;
    for (int k = 0; k < 8; k++) begin
      to_cycle(53 + 52 * k + 26);
      check($sformatf("t1_data_bit%0d", k), a_txd, exp_byte[k]);
      if (k == 4) begin
        a_start = 1'b1; @(negedge clk); cyc++; a_start = 1'b0;
      end
    end
    to_cycle(495); check("t1_stop_txd", a_txd, 1);
    to_cycle(519); check("t1_char_done_c519", a_char_done, 0);
    to_cycle(520);
    check("t1_char_done_c520", a_char_done, 1);
    check("t1_msg_done_c520", a_msg_done, 1);
    check("t1_busy_c520", a_busy, 1);
    to_cycle(521);
    check("t1_busy_c521", a_busy, 0);
    check("t1_char_done_c521", a_char_done, 0);
    check("t1_txd_c521", a_txd, 1);

    // Bit-boundary check on the 0x48 frame: bit3 spans cycles 209..260.
    go(1'b0);
    to_cycle(208); check("t1b_bit2_end", a_txd, 0);
    to_cycle(209); check("t1b_bit3_first", a_txd, 1);
    to_cycle(260); check("t1b_bit3_last", a_txd, 1);
    to_cycle(261); check("t1b_bit4_first", a_txd, 0);
    to_cycle(522);

    // "Hi\n" with repeat. Changing msg_len and repeat_en after start must have no effect.
    msg_len = 5'd3; repeat_en = 1'b1;
    go(1'b0);
    to_cycle(100); msg_len = 5'd1; repeat_en = 1'b0;
    to_cycle(520);
    check("t2_char_done_c520", a_char_done, 1);
    check("t2_msg_done_c520", a_msg_done, 0);
    to_cycle(521); check("t2_no_gap_c521", a_txd, 0);
    to_cycle(599); check("t2_i_bit0", a_txd, 1);
    to_cycle(1171); check("t2_nl_bit1", a_txd, 1);
    to_cycle(1560);
    check("t2_char_done_c1560", a_char_done, 1);
    check("t2_msg_done_c1560", a_msg_done, 1);
    to_cycle(1561); check("t2_delay_txd_first", a_txd, 1); check("t2_delay_busy", a_busy, 1);
    to_cycle(2000); check("t2_delay_txd_mid", a_txd, 1);
    to_cycle(2560); check("t2_delay_txd_last", a_txd, 1);
    to_cycle(2561); check("t2_restart_txd", a_txd, 0);
    to_cycle(2795); check("t2_restart_bit3", a_txd, 1);
    pulse_stop(2800);
    to_cycle(3080);
    check("t2_stop_char_done", a_char_done, 1);
    check("t2_stop_msg_done", a_msg_done, 0);
    to_cycle(3081); check("t2_stop_busy", a_busy, 0); check("t2_stop_txd", a_txd, 1);

    // Stop during the data bits of char 1 of 3: char 1 completes and char 2 is never sent.
    msg_len = 5'd3; repeat_en = 1'b0;
    go(1'b0);
    pulse_stop(673);
    to_cycle(1040);
    check("t4_char_done", a_char_done, 1);
    check("t4_msg_done", a_msg_done, 0);
    to_cycle(1041); check("t4_busy", a_busy, 0); check("t4_txd", a_txd, 1);
    to_cycle(1100); check("t4_still_idle", a_busy, 0);

    // Stop during the repeat gap ends the run on the next cycle.
    msg_len = 5'd1; repeat_en = 1'b1;
    go(1'b0);
    to_cycle(520); check("t5_msg_done", a_msg_done, 1);
    to_cycle(521); check("t5_delay_busy", a_busy, 1); check("t5_delay_txd", a_txd, 1);
    to_cycle(700); check("t5_busy_c700", a_busy, 1);
    pulse_stop(700);
    check("t5_idle_c701", a_busy, 0);
    to_cycle(705);

    // A write while busy raises wr_err for one cycle and leaves the buffer unchanged.
    repeat_en = 1'b0; msg_len = 5'd1;
    go(1'b0);
    to_cycle(10);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    to_cycle(11); wr_en = 1'b0;
    check("t6_wr_err_c11", a_wr_err, 1);
    to_cycle(12); check("t6_wr_err_c12", a_wr_err, 0);
    to_cycle(522);
    go(1'b0);
    to_cycle(79); check("t6_buf_bit0", a_txd, 0);
    to_cycle(209 + 26); check("t6_buf_bit3", a_txd, 1);
    to_cycle(522);
    msg_len = 5'd0;
    go(1'b0);
    check("t6_len0_busy_c1", a_busy, 0);
    to_cycle(20); check("t6_len0_busy_c20", a_busy, 0);

    // 8O2 frame carrying 0x07: parity 0, two stop bits, 12*52 cycles.
    wr(4'd0, 8'h07);
    msg_len = 5'd1;
    go(1'b1);
    check("t3_start", b_txd, 0);
    to_cycle(79);  check("t3_bit0", b_txd, 1);
    to_cycle(235); check("t3_bit3", b_txd, 0);
    to_cycle(495); check("t3_parity_mid", b_txd, 0);
    to_cycle(520); check("t3_parity_last", b_txd, 0);
    to_cycle(572); check("t3_stop1_txd", b_txd, 1); check("t3_stop1_no_done", b_char_done, 0);
    to_cycle(600); check("t3_stop2_txd", b_txd, 1);
    to_cycle(624); check("t3_char_done", b_char_done, 1); check("t3_msg_done", b_msg_done, 1);
    to_cycle(625); check("t3_busy_after", b_busy, 0);

    // Reset mid-frame, then a clean retransmission.
    go(1'b0);
    to_cycle(200); rst = 1'b1;
    to_cycle(201);
    check("t7_rst_txd", a_txd, 1);
    check("t7_rst_busy", a_busy, 0);
    check("t7_rst_char_done", a_char_done, 0);
    rst = 1'b0;
    to_cycle(203);
    go(1'b0);
    check("t7_new_txd_c1", a_txd, 0);
    check("t7_new_busy_c1", a_busy, 1);
    to_cycle(79); check("t7_new_bit0", a_txd, 1);
    to_cycle(520); check("t7_new_char_done", a_char_done, 1); check("t7_new_msg_done", a_msg_done, 1);
    to_cycle(521); check("t7_new_busy_after", a_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
